// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// the full-word byte-enable constant and the byte-lane merge helper.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } arb_state_t;

    localparam logic [3:0] BE_FULL = 4'hF;

    // Each enabled lane takes the new store byte, the others keep the old memory byte.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] wdata,
        input logic [31:0] old_data,
        input logic [3:0]  be
    );
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_data[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_arbiter_merge.sv
// Combinational 4-lane merge of store data over the current memory word,
// used to build the write-back word of a partial store.
module dmem_be_merge
    import dmem_arb_pkg::*;
(
    input  logic [31:0] wdata,
    input  logic [31:0] old_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    assign merged = merge_lanes(wdata, old_data, be);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data memory's primary port between the CPU (C) and the debug unit (D);
// partial stores become a read-modify-write. Optional statistics: define DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [3:0]        c_be,
    output logic              c_gnt,
    output logic              c_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       c_cnt,
    output logic [31:0]       d_cnt,
    output logic [7:0]        starve_max
`endif
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    arb_state_t        state, state_nxt;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] rmw_addr;
    logic [DATA_W-1:0] rmw_data;

    logic              d_win;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        sel_be;
    logic              partial;
    logic [DATA_W-1:0] merged;

    // D wins when C is quiet, or once it has been refused STARVE_LIM cycles in a row.
    assign d_win     = d_req && ((starve_cnt == LIM) || !c_req);
    assign sel_we    = d_win ? d_we    : c_we;
    assign sel_addr  = d_win ? d_addr  : c_addr;
    assign sel_wdata = d_win ? d_wdata : c_wdata;
    assign sel_be    = d_win ? d_be    : c_be;
    assign partial   = (sel_be != BE_FULL) && (sel_be != 4'h0);
    assign any_gnt   = c_gnt || d_gnt;

    dmem_be_merge u_merge (
        .wdata    (sel_wdata),
        .old_data (mem_spo),
        .be       (sel_be),
        .merged   (merged)
    );

    always_comb begin
        state_nxt = state;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        busy      = 1'b0;
        mem_a     = c_addr;
        mem_d     = '0;
        mem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst && (c_req || d_req)) begin
                    d_gnt = d_win;
                    c_gnt = !d_win;
                    mem_a = sel_addr;
                    if (sel_we) begin
                        if (sel_be == BE_FULL) begin
                            mem_we = 1'b1;
                            mem_d  = sel_wdata;
                        end else if (partial) begin
                            state_nxt = ST_RMW_WR;
                        end
                    end
                end
            end
            ST_RMW_WR: begin
                busy      = 1'b1;
                mem_a     = rmw_addr;
                mem_d     = rmw_data;
                mem_we    = !rst;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            rdata      <= '0;
            c_rvalid   <= 1'b0;
            d_rvalid   <= 1'b0;
            rmw_addr   <= '0;
            rmw_data   <= '0;
        end else begin
            state    <= state_nxt;
            c_rvalid <= c_gnt && !c_we;
            d_rvalid <= d_gnt && !d_we;
            if (any_gnt && !sel_we) begin
                rdata <= mem_spo;
            end
            if (any_gnt && sel_we && partial) begin
                rmw_addr <= sel_addr;
                rmw_data <= merged;
            end
            if (d_req && !d_gnt) begin
                starve_cnt <= (starve_cnt == LIM) ? LIM : starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_cnt      <= '0;
            d_cnt      <= '0;
            starve_max <= '0;
        end else begin
            if (c_gnt) begin
                c_cnt <= c_cnt + 32'd1;
            end
            if (d_gnt) begin
                d_cnt <= d_cnt + 32'd1;
            end
            if ({4'b0, starve_cnt} > starve_max) begin
                starve_max <= {4'b0, starve_cnt};
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter with a transaction-level memory model
// and directed scenarios pinning the model; honours DMEM_ARB_STATS_EN when defined.
module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_next = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [11:0] c_addr = '0, d_addr = '0;
    logic [31:0] c_wdata = '0, d_wdata = '0;
    logic [3:0]  c_be = '0, d_be = '0;
    logic        c_gnt, d_gnt, c_rvalid, d_rvalid, busy, mem_we;
    logic [31:0] rdata, mem_d, mem_spo;
    logic [11:0] mem_a;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] c_cnt, d_cnt;
    logic [7:0]  starve_max;
`endif

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .busy(busy),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
`ifdef DMEM_ARB_STATS_EN
        , .c_cnt(c_cnt), .d_cnt(d_cnt), .starve_max(starve_max)
`endif
    );

    always #5 clk = ~clk;

    // Environment memory (64 words) with a preload path driven by the bench.
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    assign mem_spo = mem[mem_a[5:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[5:0]] <= mem_d;
        if (pre_we) mem[pre_addr] <= pre_data;
    end

    // Reference model state.
    logic [31:0] gold [0:63];
    int          refused = 0;
    bit          pend_wr = 0;
    logic [5:0]  pend_addr = '0;
    logic [31:0] pend_data = '0;
    bit          ev_c = 0, ev_d = 0;
    logic [31:0] erdata = '0;
    bit          exp_c_gnt = 0, exp_d_gnt = 0;
    int          n_vec = 0, n_fail = 0;
    int unsigned cnt_c = 0, cnt_d = 0, smax = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model past the coming edge.
    always @(negedge clk) begin
        bit          e_cg, e_dg, e_busy, e_we, gnt, we, nc, nd;
        logic [11:0] e_a;
        logic [31:0] e_d, wd;
        logic [5:0]  a;
        logic [3:0]  b;
        if (pre_we) gold[pre_addr] = pre_data;
        if (rst) begin
            checkOutput("rst_c_gnt", 32'(c_gnt), 0);
            checkOutput("rst_d_gnt", 32'(d_gnt), 0);
            checkOutput("rst_mem_we", 32'(mem_we), 0);
            checkOutput("rst_busy", 32'(busy), 0);
            checkOutput("rst_c_rvalid", 32'(c_rvalid), 0);
            checkOutput("rst_d_rvalid", 32'(d_rvalid), 0);
            checkOutput("rst_rdata", rdata, 0);
            pend_wr = 0; refused = 0; ev_c = 0; ev_d = 0; erdata = 0;
            exp_c_gnt = 0; exp_d_gnt = 0;
            cnt_c = 0; cnt_d = 0; smax = 0;
        end else begin
            e_cg = 0; e_dg = 0; e_busy = 0; e_we = 0; e_a = c_addr; e_d = 0;
            we = 0; b = 0; wd = 0; a = 0;
            if (pend_wr) begin
                e_busy = 1; e_we = 1; e_a = {6'b0, pend_addr}; e_d = pend_data;
            end else if (d_req && (refused == LIM || !c_req)) begin
                e_dg = 1; e_a = d_addr; we = d_we; b = d_be; wd = d_wdata;
            end else if (c_req) begin
                e_cg = 1; e_a = c_addr; we = c_we; b = c_be; wd = c_wdata;
            end
            gnt = e_cg || e_dg;
            if (gnt && we && b == 4'hF) begin
                e_we = 1; e_d = wd;
            end
            checkOutput("c_gnt", 32'(c_gnt), 32'(e_cg));
            checkOutput("d_gnt", 32'(d_gnt), 32'(e_dg));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("mem_we", 32'(mem_we), 32'(e_we));
            checkOutput("mem_a", 32'(mem_a), 32'(e_a));
            if (e_we) checkOutput("mem_d", mem_d, e_d);
            checkOutput("c_rvalid", 32'(c_rvalid), 32'(ev_c));
            checkOutput("d_rvalid", 32'(d_rvalid), 32'(ev_d));
            if (ev_c || ev_d) checkOutput("rdata", rdata, erdata);

            nc = 0; nd = 0;
            a = e_a[5:0];
            if (pend_wr) begin
                gold[pend_addr] = pend_data;
                pend_wr = 0;
            end else if (gnt) begin
                if (!we) begin
                    erdata = gold[a];
                    nc = e_cg; nd = e_dg;
                end else if (b == 4'hF) begin
                    gold[a] = wd;
                end else if (b != 4'h0) begin
                    pend_wr = 1; pend_addr = a;
                    for (int i = 0; i < 4; i++)
                        pend_data[8*i +: 8] = b[i] ? wd[8*i +: 8] : gold[a][8*i +: 8];
                end
            end
            if (e_cg) cnt_c++;
            if (e_dg) cnt_d++;
            refused = (d_req && !e_dg) ? ((refused < LIM) ? refused + 1 : LIM) : 0;
            if (refused > int'(smax)) smax = refused;
            ev_c = nc; ev_d = nd;
            exp_c_gnt = e_cg; exp_d_gnt = e_dg;
        end
    end

    // One bus cycle: inputs change just after the rising edge, return just after the falling edge.
    task automatic applyStimulus(input bit cr, input bit cw, input logic [11:0] ca,
                                 input logic [31:0] cd, input logic [3:0] cb,
                                 input bit dr, input bit dw, input logic [11:0] da,
                                 input logic [31:0] dd, input logic [3:0] db);
        @(posedge clk);
        #1;
        rst = rst_next;
        pre_we = 1'b0;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd; c_be = cb;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_be = db;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 12'h0, 0, 0, 0, 0, 12'h0, 0, 0);
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = rst_next;
        c_req = 0; d_req = 0;
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        #1;
    endtask

    bit          cp, cpw, dp, dpw;
    logic [11:0] cpa, dpa;
    logic [31:0] cpd, dpd;
    logic [3:0]  cpb, dpb;

    function automatic logic [3:0] pick_be();
        int unsigned r;
        r = $urandom_range(0, 3);
        if (r == 0) return 4'hF;
        if (r == 1) return 4'h0;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
        preload(6'h10, 32'hDEADBEEF);
        preload(6'h30, 32'hAABBCCDD);
        applyStimulus(1, 0, 12'h010, 0, 0, 1, 0, 12'h020, 0, 0);
        checkOutput("reset_c_gnt_held", 32'(c_gnt), 0);
        idle();
        rst_next = 0;
        idle();

        // 1: read
        applyStimulus(1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_c_gnt", 32'(c_gnt), 1);
        idle();
        checkOutput("t1_c_rvalid", 32'(c_rvalid), 1);
        checkOutput("t1_rdata", rdata, 32'hDEADBEEF);
        // 2: full write then read back
        applyStimulus(1, 1, 12'h020, 32'h11223344, 4'hF, 0, 0, 0, 0, 0);
        checkOutput("t2_mem_we", 32'(mem_we), 1);
        applyStimulus(1, 0, 12'h020, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_c_rvalid_none", 32'(c_rvalid), 0);
        idle();
        checkOutput("t2_rdata", rdata, 32'h11223344);
        // 3: partial debug write, C blocked during RMW_WR, then reads merged word
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 12'h030, 32'h000000EE, 4'b0001);
        checkOutput("t3_d_gnt", 32'(d_gnt), 1);
        checkOutput("t3_grant_mem_we", 32'(mem_we), 0);
        applyStimulus(1, 0, 12'h030, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_busy", 32'(busy), 1);
        checkOutput("t3_c_gnt_blocked", 32'(c_gnt), 0);
        checkOutput("t3_mem_d", mem_d, 32'hAABBCCEE);
        applyStimulus(1, 0, 12'h030, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_c_gnt_after", 32'(c_gnt), 1);
        checkOutput("t3_busy_clear", 32'(busy), 0);
        idle();
        checkOutput("t3_rdata", rdata, 32'hAABBCCEE);
        // 4: starvation guard
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 0, 12'h010, 0, 0, 1, 0, 12'h020, 0, 0);
            checkOutput($sformatf("t4_c_gnt_%0d", i), 32'(c_gnt), 32'(i != 5));
            checkOutput($sformatf("t4_d_gnt_%0d", i), 32'(d_gnt), 32'(i == 5));
        end
        idle();
        // 5: zero byte-enable write
        applyStimulus(1, 1, 12'h020, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0);
        checkOutput("t5_c_gnt", 32'(c_gnt), 1);
        checkOutput("t5_mem_we", 32'(mem_we), 0);
        idle();
        checkOutput("t5_mem_we_after", 32'(mem_we), 0);
        checkOutput("t5_mem_word", mem[6'h20], 32'h11223344);
        // 6: reset during RMW_WR drops the pending write
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 12'h030, 32'h55000000, 4'b1000);
        checkOutput("t6_d_gnt", 32'(d_gnt), 1);
        rst_next = 1;
        idle();
        checkOutput("t6_busy", 32'(busy), 0);
        checkOutput("t6_mem_we", 32'(mem_we), 0);
        rst_next = 0;
        idle();
        idle();
        checkOutput("t6_mem_word", mem[6'h30], 32'hAABBCCEE);

        // Randomized traffic with held requests and occasional resets.
        cp = 0; dp = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!cp && $urandom_range(0, 3) != 0) begin
                cp = 1; cpw = 1'($urandom_range(0, 1)); cpa = 12'($urandom_range(0, 15));
                cpd = $urandom; cpb = pick_be();
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dpw = 1'($urandom_range(0, 1)); dpa = 12'($urandom_range(0, 15));
                dpd = $urandom; dpb = pick_be();
            end
            rst_next = ($urandom_range(0, 299) == 0);
            applyStimulus(cp, cpw, cp ? cpa : 12'($urandom_range(0, 15)), cpd, cpb,
                          dp, dpw, dpa, dpd, dpb);
            if (exp_c_gnt) cp = 0;
            if (exp_d_gnt) dp = 0;
        end
        rst_next = 0;
        idle();
        idle();
        idle();
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("final_mem_%0d", i), mem[i], gold[i]);
`ifdef DMEM_ARB_STATS_EN
        checkOutput("stats_c_cnt", c_cnt, cnt_c);
        checkOutput("stats_d_cnt", d_cnt, cnt_d);
        checkOutput("stats_starve_max", 32'(starve_max), smax);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
